// File: rtl/apb_fabric_pkg.sv
// rtl/apb_fabric_pkg.sv - shared state enum, select-width helper and error read data for apb_fabric
package apb_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Read data returned on decode errors and aborted transfers.
  localparam logic [31:0] ERR_RDATA = 32'h0;

  // Width of the slave index field for a fabric with nslv ports.
  function automatic int sel_w(input int nslv);
    return $clog2(nslv);
  endfunction

endpackage

// File: rtl/apb_fabric_tmo.sv
// rtl/apb_fabric_tmo.sv - ACCESS-phase cycle counter that flags expiry on the TIMEOUT-th cycle
module apb_fabric_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Held at zero outside ACCESS; counts ACCESS cycles and parks on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = !clr && (cnt == LAST);

endmodule

// File: rtl/apb_fabric.sv
// rtl/apb_fabric.sv - APB 1:NSLV fan-out with decode/slave/timeout error capture; timeout abort built only with APB_FABRIC_TIMEOUT_EN
module apb_fabric
  import apb_fabric_pkg::*;
#(
  parameter int          NSLV         = 4,
  parameter int          REGION_SHIFT = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          TIMEOUT      = 16
) (
  input  logic                 hfclk_i,
  input  logic                 erst_n_i,
  input  logic [31:0]          s_paddr,
  input  logic [31:0]          s_pwdata,
  input  logic                 s_psel,
  input  logic                 s_penable,
  input  logic                 s_pwrite,
  output logic                 s_pready,
  output logic                 s_pslverr,
  output logic [31:0]          s_prdata,
  output logic [31:0]          m_paddr,
  output logic [31:0]          m_pwdata,
  output logic                 m_pwrite,
  output logic                 m_penable,
  output logic [NSLV-1:0]      m_psel,
  input  logic [NSLV-1:0]      m_pready,
  input  logic [NSLV-1:0]      m_pslverr,
  input  logic [NSLV*32-1:0]   m_prdata,
  output logic                 err_valid,
  output logic [31:0]          err_addr,
  input  logic                 err_clr
);

  localparam int SEL_W  = sel_w(NSLV);
  localparam int HI_LSB = REGION_SHIFT + SEL_W;

  state_t            state, state_nx;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic              write_q, err_q;
  logic [SEL_W-1:0]  idx_q;

  logic              req, hit, active, tmo_expire;
  logic [SEL_W-1:0]  idx_in;
  logic              sel_ready, sel_err;
  logic [31:0]       sel_rdata;
  logic              resp_ld, resp_err_nx;
  logic [31:0]       resp_data_nx;
  logic [31:0]       fail_addr;

  assign req    = s_psel & s_penable;
  assign hit    = (s_paddr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign idx_in = s_paddr[HI_LSB-1:REGION_SHIFT];
  assign active = (state == ST_SETUP) || (state == ST_ACCESS);

  assign sel_ready = m_pready[idx_q];
  assign sel_err   = m_pslverr[idx_q];
  assign sel_rdata = m_prdata[{idx_q, 5'd0} +: 32];

`ifdef APB_FABRIC_TIMEOUT_EN
  apb_fabric_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (hfclk_i),
    .rst_n  (erst_n_i),
    .clr    (state != ST_ACCESS),
    .expire (tmo_expire)
  );
`else
  // No abort path: ACCESS waits for m_pready indefinitely, so expiry can never assert.
  assign tmo_expire = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge hfclk_i or negedge erst_n_i) begin
    if (!erst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and the response to be captured on entry to RESP.
  always_comb begin
    state_nx     = state;
    resp_ld      = 1'b0;
    resp_err_nx  = 1'b0;
    resp_data_nx = ERR_RDATA;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            state_nx = ST_SETUP;
          end else begin
            state_nx    = ST_RESP;
            resp_ld     = 1'b1;
            resp_err_nx = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_nx     = ST_RESP;
          resp_ld      = 1'b1;
          resp_err_nx  = sel_err;
          resp_data_nx = sel_rdata;
        end else if (tmo_expire) begin
          state_nx    = ST_RESP;
          resp_ld     = 1'b1;
          resp_err_nx = 1'b1;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Latch the upstream request when accepted and the response when it resolves.
  always_ff @(posedge hfclk_i or negedge erst_n_i) begin
    if (!erst_n_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && req) begin
        addr_q  <= s_paddr;
        wdata_q <= s_pwdata;
        write_q <= s_pwrite;
        idx_q   <= idx_in;
      end
      if (resp_ld) begin
        rdata_q <= resp_data_nx;
        err_q   <= resp_err_nx;
      end
    end
  end

  // A decode miss resolves in the accept cycle, before addr_q holds the address.
  assign fail_addr = (state == ST_IDLE) ? s_paddr : addr_q;

  // Sticky first-error capture; a simultaneous new error beats err_clr.
  always_ff @(posedge hfclk_i or negedge erst_n_i) begin
    if (!erst_n_i) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (resp_ld && resp_err_nx && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= fail_addr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end

  assign m_psel    = active ? (NSLV'(1) << idx_q) : '0;
  assign m_penable = (state == ST_ACCESS);
  assign m_paddr   = active ? addr_q  : '0;
  assign m_pwdata  = active ? wdata_q : '0;
  assign m_pwrite  = active & write_q;

  assign s_pready  = (state == ST_RESP);
  assign s_prdata  = (state == ST_RESP) ? rdata_q : '0;
  assign s_pslverr = (state == ST_RESP) & err_q;

endmodule

// File: tb/tb_apb_fabric.sv
// tb/tb_apb_fabric.sv - scoreboard bench for apb_fabric (timeout checks follow APB_FABRIC_TIMEOUT_EN)
module tb_apb_fabric;

  localparam int          NSLV = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          HANG = 1000000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        s_paddr = '0, s_pwdata = '0;
  logic               s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
  logic               s_pready, s_pslverr;
  logic [31:0]        s_prdata;
  logic [31:0]        m_paddr, m_pwdata;
  logic               m_pwrite, m_penable;
  logic [NSLV-1:0]    m_psel;
  logic [NSLV-1:0]    m_pready = '0;
  logic [NSLV-1:0]    m_pslverr = '0;
  logic [NSLV*32-1:0] m_prdata = '0;
  logic               err_valid;
  logic [31:0]        err_addr;
  logic               err_clr = 1'b0;

  always #5 clk = ~clk;

  apb_fabric #(
    .NSLV(NSLV), .REGION_SHIFT(12), .BASE_ADDR(BASE), .TIMEOUT(TMO)
  ) dut (
    .hfclk_i(clk), .erst_n_i(rst_n),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwrite(s_pwrite), .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite), .m_penable(m_penable),
    .m_psel(m_psel), .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @cyc %0d", name, act, req, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at_cyc;
    logic        ev;
    logic [31:0] ea;
  } exp_t;

  exp_t exp_q[$];

  // Reference error-capture state.
  logic        ev_m = 1'b0;
  logic [31:0] ea_m = '0;

  // Slave-side expectations for the transfer in flight.
  int          exp_idx = 0;
  int          wait_n = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        exp_write = 1'b0;
  logic        no_sel = 1'b0;
  int          acnt = 0;

  // Slave model: answers only on the expected lane after wait_n wait states.
  always @(negedge clk) begin
    if (!rst_n) begin
      acnt = 0;
      m_pready = '0;
    end else begin
      if (no_sel && (m_psel != '0)) chk("miss_psel", {28'd0, m_psel}, 32'd0);
      if (m_penable && m_psel[exp_idx]) begin
        if (acnt == 0) begin
          chk("m_psel", {28'd0, m_psel}, 32'd1 << exp_idx);
          chk("m_paddr", m_paddr, exp_addr);
          chk("m_pwdata", m_pwdata, exp_wdata);
          chk("m_pwrite", {31'd0, m_pwrite}, {31'd0, exp_write});
        end
        m_pready = '0;
        if (acnt == wait_n) m_pready[exp_idx] = 1'b1;
        acnt++;
      end else begin
        acnt = 0;
        m_pready = '0;
      end
    end
  end

  exp_t got_e;

  // Monitor: every upstream response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && s_pready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready actual=1 required=0 @cyc %0d", cyc);
      end else begin
        got_e = exp_q.pop_front();
        chk("s_prdata", s_prdata, got_e.rdata);
        chk("s_pslverr", {31'd0, s_pslverr}, {31'd0, got_e.err});
        chk("latency_cyc", cyc, got_e.at_cyc);
        chk("resp_m_psel", {28'd0, m_psel}, 32'd0);
        chk("err_valid", {31'd0, err_valid}, {31'd0, got_e.ev});
        if (got_e.ev) chk("err_addr", err_addr, got_e.ea);
      end
    end
  end

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int wt, input logic se, input logic [31:0] rv, input logic clr_with);
    logic hit;
    int   idx;
    logic tmo;
    logic got;
    exp_t e;
    hit = ((addr >> 14) == (BASE >> 14));
    idx = int'((addr >> 12) % NSLV);
`ifdef APB_FABRIC_TIMEOUT_EN
    tmo = hit && (wt >= TMO);
`else
    tmo = 1'b0;
`endif
    exp_idx = idx; wait_n = wt; exp_addr = addr; exp_write = wr; exp_wdata = wd; no_sel = !hit;
    for (int i = 0; i < NSLV; i++) begin
      m_prdata[32*i +: 32] = (i == idx) ? rv : (~rv ^ i);
      m_pslverr[i] = (i == idx) ? se : 1'b1;
    end
    if (!hit) begin
      e.rdata = 32'h0; e.err = 1'b1; e.at_cyc = 1;
    end else if (tmo) begin
      e.rdata = 32'h0; e.err = 1'b1; e.at_cyc = 2 + TMO;
    end else begin
      e.rdata = rv; e.err = se; e.at_cyc = 3 + wt;
    end
    @(posedge clk); #1;
    s_paddr = addr; s_pwrite = wr; s_pwdata = wd; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clk); #1;
    s_penable = 1'b1;
    err_clr = clr_with;
    if (e.err && (!ev_m || clr_with)) begin
      ev_m = 1'b1;
      ea_m = addr;
    end else if (clr_with) begin
      ev_m = 1'b0;
    end
    e.at_cyc = e.at_cyc + cyc;
    e.ev = ev_m;
    e.ea = ea_m;
    exp_q.push_back(e);
    @(posedge clk); #1;
    err_clr = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (s_pready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL no_pready addr=%h actual=0 required=1", addr);
      exp_q.delete();
    end
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0; no_sel = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    ev_m = 1'b0;
    @(negedge clk);
    chk("err_clr", {31'd0, err_valid}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_pready"}, {31'd0, s_pready}, 32'd0);
    chk({tag, "_s_prdata"}, s_prdata, 32'd0);
    chk({tag, "_s_pslverr"}, {31'd0, s_pslverr}, 32'd0);
    chk({tag, "_m_psel"}, {28'd0, m_psel}, 32'd0);
    chk({tag, "_m_penable"}, {31'd0, m_penable}, 32'd0);
    chk({tag, "_m_paddr"}, m_paddr, 32'd0);
    chk({tag, "_m_pwdata"}, m_pwdata, 32'd0);
    chk({tag, "_m_pwrite"}, {31'd0, m_pwrite}, 32'd0);
    chk({tag, "_err_valid"}, {31'd0, err_valid}, 32'd0);
    chk({tag, "_err_addr"}, err_addr, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          pr_seen;
    logic        seen;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed cases.
    xfer(32'h4000_1008, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0BAD_F00D, 1'b0);
    xfer(32'h4000_3000, 1'b0, 32'h0, 3, 1'b0, 32'hCAFE_0001, 1'b0);
    xfer(32'h5000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_2222, 1'b0);
    xfer(32'h6000_0004, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
    xfer(32'h7000_0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0);
    xfer(32'h4000_2010, 1'b0, 32'h0, 1, 1'b1, 32'h5555_AAAA, 1'b0);
    pulse_clr();
    xfer(32'h4000_0ffc, 1'b0, 32'h0, TMO - 1, 1'b0, 32'h7777_1234, 1'b0);
`ifdef APB_FABRIC_TIMEOUT_EN
    xfer(32'h4000_2000, 1'b0, 32'h0, HANG, 1'b0, 32'h9999_0000, 1'b0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) != 0) begin
        a = BASE | ($urandom_range(0, NSLV - 1) << 12) | ($urandom & 32'h0000_0ffc);
        xfer(a, 1'($urandom), $urandom, $urandom_range(0, 4),
             ($urandom_range(0, 7) == 0), $urandom, 1'b0);
      end else begin
        a = $urandom;
        if ((a >> 14) == (BASE >> 14)) a = a ^ 32'h8000_0000;
        xfer(a, 1'($urandom), $urandom, 0, 1'b0, $urandom, ($urandom_range(0, 2) == 0));
      end
      if ($urandom_range(0, 6) == 0) pulse_clr();
    end

    // Hung slave 2, then asynchronous reset during ACCESS.
    exp_idx = 2; wait_n = HANG; exp_addr = 32'h4000_2000; exp_write = 1'b0; exp_wdata = 32'h0;
    @(posedge clk); #1;
    s_paddr = 32'h4000_2000; s_pwrite = 1'b0; s_pwdata = 32'h0; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clk); #1 s_penable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (m_penable) seen = 1'b1;
    end
    chk("hang_access_reached", {31'd0, seen}, 32'd1);
`ifndef APB_FABRIC_TIMEOUT_EN
    pr_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_pready) pr_seen++;
    end
    chk("hang_no_pready", pr_seen, 0);
    chk("hang_m_psel", {28'd0, m_psel}, 32'h4);
`else
    pr_seen = 0;
    @(negedge clk);
`endif
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    ev_m = 1'b0; ea_m = '0;
    exp_q.delete();
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    xfer(32'h4000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0102_0304, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
